// File: rtl/handshake_fifo_buffer_pkg.sv
// handshake_fifo_buffer_pkg
//   Shared helpers for the handshake buffer family:
//     count_width() - bits needed to hold an occupancy of 0..depth
//     ptr_inc()     - pointer increment with explicit wrap at depth-1,
//                     safe for non-power-of-two depths
package handshake_fifo_buffer_pkg;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit compare-and-wrap so non-power-of-two depths never index
    // past the last slot.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                            input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/handshake_fifo_buffer_if.sv
// handshake_fifo_buffer_if
//   Upstream and downstream handshake channels of the buffer.
//     ins / ins_valid / ins_ready    : producer -> buffer
//     outs / outs_valid / outs_ready : buffer -> consumer
//   master: environment view (drives ins side, accepts outs side)
//   slave : buffer view
interface handshake_fifo_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_valid;
    logic                  outs_ready;

    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_valid
    );

    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_valid
    );
endinterface

// File: rtl/handshake_fifo_mem.sv
// handshake_fifo_mem
//   DEPTH x DATA_WIDTH register array, one synchronous write port and one
//   asynchronous read port. Contents are not reset.
//     clk             : write clock
//     wr_en/wr_addr/wr_data : write port
//     rd_addr/rd_data : combinational read port
module handshake_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/handshake_fifo_buffer.sv
// handshake_fifo_buffer
//   Elastic, non-transparent FIFO for the handshake fabric. Holds up to
//   DEPTH tokens; output comes from registered storage so there is at
//   least one cycle of latency and no in->out combinational path.
//     clk, rst : clock, asynchronous active-high reset
//     bus      : slave modport carrying ins/ins_valid/ins_ready and
//                outs/outs_valid/outs_ready
module handshake_fifo_buffer
    import handshake_fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic                    clk,
    input logic                    rst,
    handshake_fifo_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full, empty, push, pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Ready is from state only, never from outs_ready: a pop on a full
    // buffer frees the slot for the next cycle, not this one.
    assign bus.ins_ready  = !rst && !full;
    assign bus.outs_valid = !empty;
    assign bus.outs       = empty ? '0 : rd_data;

    assign push = bus.ins_valid && bus.ins_ready;
    assign pop  = bus.outs_valid && bus.outs_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
            if (pop)  rd_ptr_q <= PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    handshake_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.ins),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );
endmodule
